// File: rtl/sweep_response_meter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : sweep_pkg                                                      |
// | Purpose  : Shared sweep definitions for the DDS step generator and the    |
// |            sweep response meter (step count, step index type, FSM state). |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package sweep_pkg;

  localparam int N_STEPS_DEF    = 50;
  localparam int SAMPLE_RATE_HZ = 163840;

  typedef logic [5:0] step_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    STORE   = 2'd3
  } meter_state_t;

  // Step indices are 1-based; 0 and anything beyond the sweep length are invalid.
  function automatic logic idx_in_range(input step_idx_t idx, input int unsigned n_steps);
    return (idx != '0) && ({26'd0, idx} <= n_steps);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sweep_response_meter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface: sweep_response_meter_if                                        |
// | Purpose  : Sample/step input, result, readback and error signals of the   |
// |            sweep response meter. SWEEP_RESPONSE_METER_DC_EN adds the DC   |
// |            mean result and its readback.                                  |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface sweep_response_meter_if #(
  parameter int DW = 12
);
  import sweep_pkg::*;

  logic          sample_en;
  logic [DW-1:0] adc_data;
  logic          step_start;
  step_idx_t     step_idx;
  logic          res_valid;
  step_idx_t     res_idx;
  logic [DW-1:0] res_pp;
  logic          sweep_done;
  step_idx_t     rd_addr;
  logic [DW-1:0] rd_data;
  logic          err_abort;
  logic          err_idx;
`ifdef SWEEP_RESPONSE_METER_DC_EN
  logic [DW-1:0] res_dc;
  logic [DW-1:0] rd_dc;

  modport master (
    output sample_en, adc_data, step_start, step_idx, rd_addr,
    input  res_valid, res_idx, res_pp, sweep_done, rd_data, err_abort, err_idx,
    input  res_dc, rd_dc
  );

  modport slave (
    input  sample_en, adc_data, step_start, step_idx, rd_addr,
    output res_valid, res_idx, res_pp, sweep_done, rd_data, err_abort, err_idx,
    output res_dc, rd_dc
  );
`else
  modport master (
    output sample_en, adc_data, step_start, step_idx, rd_addr,
    input  res_valid, res_idx, res_pp, sweep_done, rd_data, err_abort, err_idx
  );

  modport slave (
    input  sample_en, adc_data, step_start, step_idx, rd_addr,
    output res_valid, res_idx, res_pp, sweep_done, rd_data, err_abort, err_idx
  );
`endif

endinterface
`default_nettype wire

// File: rtl/sweep_response_meter_minmax_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : minmax_tracker                                                 |
// | Purpose  : Running minimum/maximum of a sample stream with peak-to-peak   |
// |            output (max - min).                                            |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module minmax_tracker #(
  parameter int DW = 12
) (
  input  wire logic          clk_4096,
  input  wire logic          rst,
  input  wire logic          i_clr,
  input  wire logic          i_upd,
  input  wire logic [DW-1:0] i_din,
  output logic      [DW-1:0] o_pp
);

  logic [DW-1:0] r_min;
  logic [DW-1:0] r_max;

  // Clear loads the neutral extremes so the first update sets both min and max.
  always_ff @(posedge clk_4096) begin
    if (!rst) begin
      r_min <= '1;
      r_max <= '0;
    end else if (i_clr) begin
      r_min <= '1;
      r_max <= '0;
    end else if (i_upd) begin
      if (i_din < r_min) r_min <= i_din;
      if (i_din > r_max) r_max <= i_din;
    end
  end

  // Only sampled after at least one update, so max >= min and this never wraps.
  assign o_pp = r_max - r_min;

endmodule
`default_nettype wire

// File: rtl/sweep_response_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sweep_response_meter                                           |
// | Purpose  : Per-step peak-to-peak amplitude measurement of the DUT         |
// |            response during a stepped-frequency sweep, with a result       |
// |            buffer for host/FFT readback.                                  |
// | Options  : SWEEP_RESPONSE_METER_DC_EN adds a window mean (res_dc) and a   |
// |            second readback buffer (rd_dc).                                |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module sweep_response_meter
  import sweep_pkg::*;
#(
  parameter int N_STEPS        = N_STEPS_DEF,
  parameter int SETTLE_SAMPLES = 8192,
  parameter int MEAS_LOG2      = 16,
  parameter int DW             = 12
) (
  input  wire logic             clk_4096,
  input  wire logic             rst,
  sweep_response_meter_if.slave bus
);

  // One counter serves both the settle and measurement phases.
  localparam int c_cnt_w = ((MEAS_LOG2 > $clog2(SETTLE_SAMPLES)) ? MEAS_LOG2
                                                                  : $clog2(SETTLE_SAMPLES)) + 1;
  localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_SAMPLES - 1);
  localparam logic [c_cnt_w-1:0] c_meas_last   = c_cnt_w'((2 ** MEAS_LOG2) - 1);

  meter_state_t         r_state;
  meter_state_t         w_next;
  step_idx_t            r_idx;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_err_abort;
  logic                 r_err_idx;
  logic [DW-1:0]        r_rd_data;
  logic [DW-1:0]        r_mem [1:N_STEPS];

  logic                 w_cnt_clr;
  logic                 w_cnt_inc;
  logic                 w_idx_load;
  logic                 w_set_abort;
  logic                 w_set_err_idx;
  logic                 w_mm_clr;
  logic                 w_mm_upd;
  logic                 w_we;
  logic                 w_idx_ok;
  logic                 w_rd_ok;
  logic                 w_valid;
  logic [DW-1:0]        w_pp;

  assign w_idx_ok = idx_in_range(bus.step_idx, int'(N_STEPS));
  assign w_rd_ok  = idx_in_range(bus.rd_addr, int'(N_STEPS));

  minmax_tracker #(.DW(DW)) u_minmax (
    .clk_4096 (clk_4096),
    .rst      (rst),
    .i_clr    (w_mm_clr),
    .i_upd    (w_mm_upd),
    .i_din    (bus.adc_data),
    .o_pp     (w_pp)
  );

  // State register.
  always_ff @(posedge clk_4096) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next state and datapath controls; a step_start overrides any strobe in the same cycle.
  always_comb begin
    w_next        = r_state;
    w_cnt_clr     = 1'b0;
    w_cnt_inc     = 1'b0;
    w_idx_load    = 1'b0;
    w_set_abort   = 1'b0;
    w_set_err_idx = 1'b0;
    w_mm_clr      = 1'b0;
    w_mm_upd      = 1'b0;
    w_we          = 1'b0;
    case (r_state)
      IDLE: ;
      SETTLE: begin
        if (bus.sample_en) begin
          if (r_cnt == c_settle_last) begin
            w_next    = MEASURE;
            w_cnt_clr = 1'b1;
            w_mm_clr  = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      MEASURE: begin
        if (bus.sample_en) begin
          w_mm_upd = 1'b1;
          if (r_cnt == c_meas_last) w_next = STORE;
          else                      w_cnt_inc = 1'b1;
        end
      end
      STORE: begin
        w_we   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (bus.step_start) begin
      w_cnt_inc = 1'b0;
      w_mm_upd  = 1'b0;
      w_mm_clr  = 1'b0;
      if (r_state == SETTLE || r_state == MEASURE) w_set_abort = 1'b1;
      if (w_idx_ok) begin
        w_next     = SETTLE;
        w_idx_load = 1'b1;
        w_cnt_clr  = 1'b1;
      end else begin
        w_next        = IDLE;
        w_set_err_idx = 1'b1;
      end
    end
  end

  // Sample counter, latched step index and sticky error flags.
  always_ff @(posedge clk_4096) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_err_abort <= 1'b0;
      r_err_idx   <= 1'b0;
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      if (w_idx_load)     r_idx <= bus.step_idx;
      if (w_set_abort)    r_err_abort <= 1'b1;
      if (w_set_err_idx)  r_err_idx   <= 1'b1;
    end
  end

  // Result buffer keeps its contents through reset; a write never lands while reset is held.
  always_ff @(posedge clk_4096) begin
    if (w_we && rst) r_mem[r_idx] <= w_pp;
  end

  // Registered readback; a same-cycle write to the address returns the previous value.
  always_ff @(posedge clk_4096) begin
    if (!rst)         r_rd_data <= '0;
    else if (w_rd_ok) r_rd_data <= r_mem[bus.rd_addr];
    else              r_rd_data <= '0;
  end

  assign w_valid        = (r_state == STORE);
  assign bus.res_valid  = w_valid;
  assign bus.res_idx    = w_valid ? r_idx : '0;
  assign bus.res_pp     = w_valid ? w_pp  : '0;
  assign bus.sweep_done = w_valid && (r_idx == step_idx_t'(N_STEPS));
  assign bus.rd_data    = r_rd_data;
  assign bus.err_abort  = r_err_abort;
  assign bus.err_idx    = r_err_idx;

`ifdef SWEEP_RESPONSE_METER_DC_EN
  logic [DW+MEAS_LOG2-1:0] r_acc;
  logic [DW-1:0]           w_dc;
  logic [DW-1:0]           r_rd_dc;
  logic [DW-1:0]           r_mem_dc [1:N_STEPS];

  // Window sum, cleared on entry to MEASURE alongside the min/max registers.
  always_ff @(posedge clk_4096) begin
    if (!rst)          r_acc <= '0;
    else if (w_mm_clr) r_acc <= '0;
    else if (w_mm_upd) r_acc <= r_acc + {{MEAS_LOG2{1'b0}}, bus.adc_data};
  end

  assign w_dc = r_acc[DW+MEAS_LOG2-1:MEAS_LOG2];

  // DC result buffer, written in the same cycle as the amplitude buffer.
  always_ff @(posedge clk_4096) begin
    if (w_we && rst) r_mem_dc[r_idx] <= w_dc;
  end

  // Registered DC readback with the same timing as rd_data.
  always_ff @(posedge clk_4096) begin
    if (!rst)         r_rd_dc <= '0;
    else if (w_rd_ok) r_rd_dc <= r_mem_dc[bus.rd_addr];
    else              r_rd_dc <= '0;
  end

  assign bus.res_dc = w_valid ? w_dc : '0;
  assign bus.rd_dc  = r_rd_dc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sweep_response_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sweep_response_meter                                        |
// | Purpose  : Directed self-checking bench for sweep_response_meter with a   |
// |            4-sample settle and 8-sample window. SWEEP_RESPONSE_METER_DC_EN|
// |            enables the DC mean scenario.                                  |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_sweep_response_meter;
  import sweep_pkg::*;

  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rv_count = 0;
  int   sd_count = 0;
  int   last_idx = 0;
  int   last_pp  = 0;
  logic [DW-1:0] win [8];

  always #5 clk = ~clk;

  sweep_response_meter_if #(.DW(DW)) bus ();

  sweep_response_meter #(
    .N_STEPS        (50),
    .SETTLE_SAMPLES (4),
    .MEAS_LOG2      (3),
    .DW             (DW)
  ) dut (
    .clk_4096 (clk),
    .rst      (rst),
    .bus      (bus)
  );

  // Result and sweep-done pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.res_valid === 1'b1) begin
      rv_count = rv_count + 1;
      last_idx = int'(bus.res_idx);
      last_pp  = int'(bus.res_pp);
    end
    if (bus.sweep_done === 1'b1) sd_count = sd_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [DW-1:0] d);
    bus.sample_en = 1'b1;
    bus.adc_data  = d;
    tick();
    bus.sample_en = 1'b0;
  endtask

  task automatic start(input int idx);
    bus.step_start = 1'b1;
    bus.step_idx   = 6'(idx);
    tick();
    bus.step_start = 1'b0;
  endtask

  // Window samples are base + k*delta for k=0..7 in shuffled order, so pp = 7*delta.
  task automatic set_win(input int base, input int delta);
    int perm [8] = '{3, 0, 7, 2, 5, 1, 6, 4};
    for (int i = 0; i < 8; i++) win[i] = DW'(base + perm[i] * delta);
  endtask

  // Leaves time just after the final strobe edge, i.e. inside the STORE cycle.
  task automatic run_step(input int idx);
    start(idx);
    repeat (4) strobe(12'hFFF);
    for (int i = 0; i < 8; i++) strobe(win[i]);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({bus.res_valid, bus.sweep_done, bus.err_abort, bus.err_idx} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000",
               {bus.res_valid, bus.sweep_done, bus.err_abort, bus.err_idx});
    end
    n_checks++;
    if ({bus.res_idx, bus.res_pp, bus.rd_data} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_data: res_idx=%0d res_pp=%0d rd_data=%0d expected all 0",
               bus.res_idx, bus.res_pp, bus.rd_data);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_amplitude();
    int rv0;
    rv0 = rv_count;
    win = '{12'd100, 12'd900, 12'd500, 12'd2000, 12'd1500, 12'd300, 12'd800, 12'd700};
    start(5);
    repeat (4) strobe(12'hFFF);
    for (int i = 0; i < 7; i++) strobe(win[i]);
    n_checks++;
    if (bus.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL amp_early_valid: got %b expected 0", bus.res_valid);
    end
    strobe(win[7]);
    n_checks++;
    if (bus.res_valid !== 1'b1 || bus.res_idx !== 6'd5 || bus.res_pp !== 12'd1900) begin
      n_fail++;
      $display("FAIL amp_result: valid=%b idx=%0d pp=%0d expected 1/5/1900",
               bus.res_valid, bus.res_idx, bus.res_pp);
    end
    tick();
    bus.rd_addr = 6'd5;
    tick();
    n_checks++;
    if (bus.rd_data !== 12'd1900) begin
      n_fail++;
      $display("FAIL amp_readback: got %0d expected 1900", bus.rd_data);
    end
    n_checks++;
    if (rv_count - rv0 !== 1) begin
      n_fail++;
      $display("FAIL amp_pulse_count: got %0d expected 1", rv_count - rv0);
    end
  endtask

  task automatic test_abort();
    int rv0;
    set_win(10, 10);
    run_step(7);
    tick();
    n_checks++;
    if (bus.err_abort !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pre_flag: got %b expected 0", bus.err_abort);
    end
    start(7);
    repeat (4) strobe(12'hFFF);
    strobe(12'd0);
    strobe(12'hFFF);
    rv0 = rv_count;
    set_win(1000, 79);
    run_step(8);
    tick();
    n_checks++;
    if (bus.err_abort !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_flag: got %b expected 1", bus.err_abort);
    end
    n_checks++;
    if (rv_count - rv0 !== 1 || last_idx !== 8 || last_pp !== 553) begin
      n_fail++;
      $display("FAIL abort_result: pulses=%0d idx=%0d pp=%0d expected 1/8/553",
               rv_count - rv0, last_idx, last_pp);
    end
    bus.rd_addr = 6'd7;
    tick();
    n_checks++;
    if (bus.rd_data !== 12'd70) begin
      n_fail++;
      $display("FAIL abort_buf7: got %0d expected 70", bus.rd_data);
    end
  endtask

  task automatic test_sweep_end();
    int sd0;
    sd0 = sd_count;
    set_win(200, 5);
    run_step(49);
    n_checks++;
    if (bus.res_valid !== 1'b1 || bus.sweep_done !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_49: valid=%b done=%b expected 1/0", bus.res_valid, bus.sweep_done);
    end
    tick();
    set_win(300, 6);
    run_step(50);
    n_checks++;
    if (bus.sweep_done !== 1'b1 || bus.res_idx !== 6'd50 || bus.res_pp !== 12'd42) begin
      n_fail++;
      $display("FAIL sweep_50: done=%b idx=%0d pp=%0d expected 1/50/42",
               bus.sweep_done, bus.res_idx, bus.res_pp);
    end
    tick();
    n_checks++;
    if (sd_count - sd0 !== 1 || bus.sweep_done !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_done_count: pulses=%0d now=%b expected 1/0",
               sd_count - sd0, bus.sweep_done);
    end
  endtask

  task automatic test_invalid_idx();
    int rv0;
    rv0 = rv_count;
    n_checks++;
    if (bus.err_idx !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_pre_flag: got %b expected 0", bus.err_idx);
    end
    start(0);
    n_checks++;
    if (bus.err_idx !== 1'b1) begin
      n_fail++;
      $display("FAIL inv_flag: got %b expected 1", bus.err_idx);
    end
    repeat (12) strobe(12'h123);
    start(51);
    repeat (12) strobe(12'h456);
    tick();
    n_checks++;
    if (rv_count - rv0 !== 0 || bus.err_idx !== 1'b1) begin
      n_fail++;
      $display("FAIL inv_idle: pulses=%0d err_idx=%b expected 0/1", rv_count - rv0, bus.err_idx);
    end
  endtask

  task automatic test_collision();
    bus.rd_addr    = 6'd5;
    bus.step_start = 1'b1;
    bus.step_idx   = 6'd5;
    bus.sample_en  = 1'b1;
    bus.adc_data   = 12'd0;
    tick();
    bus.step_start = 1'b0;
    bus.sample_en  = 1'b0;
    repeat (4) strobe(12'hFFF);
    set_win(50, 100);
    for (int i = 0; i < 7; i++) strobe(win[i]);
    n_checks++;
    if (bus.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_sample_counted: valid=%b expected 0", bus.res_valid);
    end
    strobe(win[7]);
    n_checks++;
    if (bus.res_valid !== 1'b1 || bus.res_pp !== 12'd700) begin
      n_fail++;
      $display("FAIL coll_result: valid=%b pp=%0d expected 1/700", bus.res_valid, bus.res_pp);
    end
    tick();
    n_checks++;
    if (bus.rd_data !== 12'd1900) begin
      n_fail++;
      $display("FAIL coll_rw_old: got %0d expected 1900", bus.rd_data);
    end
    tick();
    n_checks++;
    if (bus.rd_data !== 12'd700) begin
      n_fail++;
      $display("FAIL coll_rw_new: got %0d expected 700", bus.rd_data);
    end
  endtask

`ifdef SWEEP_RESPONSE_METER_DC_EN
  task automatic test_dc();
    for (int i = 0; i < 8; i++) win[i] = 12'h800;
    run_step(30);
    n_checks++;
    if (bus.res_dc !== 12'h800 || bus.res_pp !== 12'd0) begin
      n_fail++;
      $display("FAIL dc_result: dc=%h pp=%0d expected 800/0", bus.res_dc, bus.res_pp);
    end
    tick();
    bus.rd_addr = 6'd30;
    tick();
    n_checks++;
    if (bus.rd_dc !== 12'h800) begin
      n_fail++;
      $display("FAIL dc_readback: got %h expected 800", bus.rd_dc);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int rv0;
    set_win(100, 20);
    run_step(20);
    tick();
    bus.rd_addr = 6'd20;
    start(20);
    repeat (4) strobe(12'hFFF);
    strobe(12'd0);
    strobe(12'hFFF);
    strobe(12'd2000);
    rst = 1'b0;
    tick();
    n_checks++;
    if ({bus.res_valid, bus.sweep_done, bus.err_abort, bus.err_idx} !== 4'b0000 ||
        {bus.res_idx, bus.res_pp, bus.rd_data} !== 30'd0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: flags=%b idx=%0d pp=%0d rd=%0d expected all 0",
               {bus.res_valid, bus.sweep_done, bus.err_abort, bus.err_idx},
               bus.res_idx, bus.res_pp, bus.rd_data);
    end
    rst = 1'b1;
    rv0 = rv_count;
    repeat (6) strobe(12'd0);
    tick();
    n_checks++;
    if (rv_count - rv0 !== 0 || bus.rd_data !== 12'd140) begin
      n_fail++;
      $display("FAIL mid_reset_nowrite: pulses=%0d buf20=%0d expected 0/140",
               rv_count - rv0, bus.rd_data);
    end
  endtask

  initial begin
    bus.sample_en  = 1'b0;
    bus.adc_data   = '0;
    bus.step_start = 1'b0;
    bus.step_idx   = '0;
    bus.rd_addr    = '0;
    test_reset();
    test_amplitude();
    test_abort();
    test_sweep_end();
    test_invalid_idx();
    test_collision();
`ifdef SWEEP_RESPONSE_METER_DC_EN
    test_dc();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sweep_response_meter.md
Name: sweep_response_meter

Overview:
- Receive-side counterpart of the stepped-frequency DDS sweep generator.
- Consumes ADC samples of the device-under-test response at the sweep sample rate, one measurement window per frequency step.
- Measures peak-to-peak amplitude per step and stores 50 results in an internal buffer; the FFT/host side reads them back after the sweep.

Parameters:
- N_STEPS, 50, number of frequency points per sweep; valid step indices are 1..N_STEPS.
- SETTLE_SAMPLES, 8192, samples discarded after each step change.
- MEAS_LOG2, 16, log2 of the measurement window length in samples (default window 65536).
- DW, 12, ADC sample width, unsigned offset-binary.

Ports:
- clk_4096  in  1  40.96 MHz system clock.
- rst  in  1  synchronous reset, active-low.
- sample_en  in  1  one-cycle strobe per ADC sample (163840 Hz).
- adc_data  in  DW  sample; valid only when sample_en=1.
- step_start  in  1  one-cycle pulse: a new frequency is applied.
- step_idx  in  6  index of the new step, sampled on step_start.
- res_valid  out  1  one-cycle pulse when a result is written.
- res_idx  out  6  step index of the written result.
- res_pp  out  DW  peak-to-peak amplitude of the written result.
- sweep_done  out  1  one-cycle pulse when step N_STEPS is stored.
- rd_addr  in  6  readback address, 1..N_STEPS.
- rd_data  out  DW  stored amplitude at rd_addr.
- err_abort  out  1  sticky: a step was aborted by an early step_start.
- err_idx  out  1  sticky: step_start arrived with step_idx of 0 or >N_STEPS.

Behaviour:
- Reset (rst=0 at a clk_4096 edge):
  - State goes to IDLE; all counters clear.
  - res_valid, sweep_done, err_abort and err_idx clear; res_idx, res_pp and rd_data go to 0.
  - Buffer contents are not cleared.
  - Reset mid-measurement discards the partial result; nothing is written.
- States: IDLE, SETTLE, MEASURE, STORE.
- IDLE: wait for step_start.
  - If step_idx is valid: latch it, clear the sample counter, go to SETTLE.
  - If step_idx is invalid: set err_idx and stay in IDLE.
- SETTLE: count sample_en strobes.
  - On the SETTLE_SAMPLES-th strobe, go to MEASURE. That sample is discarded.
  - Load min=all-ones and max=0.
- MEASURE: on each strobe, update min/max with adc_data and increment the counter.
  - On the 2^MEAS_LOG2-th strobe (that sample included), go to STORE.
- STORE (exactly one cycle):
  - Write pp = max - min (DW bits, cannot underflow) to buffer[idx].
  - Drive res_valid=1 with res_idx=idx and res_pp=pp.
  - Pulse sweep_done in the same cycle if idx==N_STEPS.
  - Next state is IDLE.
- step_start while in SETTLE or MEASURE:
  - Abort the current step with no write and set err_abort.
  - Restart SETTLE with the new index if it is valid; otherwise set err_idx and go to IDLE.
- step_start while in STORE: the store completes, then the new step is accepted in that same cycle (store has priority, no abort).
- sample_en and step_start in the same cycle: step_start wins; the sample is not counted.
- sample_en is ignored in IDLE and STORE.
- Readback:
  - rd_data is registered, 1-cycle latency from rd_addr.
  - rd_addr out of range returns 0.
  - A read and a write to the same address in the same cycle return the old value.
- Buffer: N_STEPS x DW, synchronous write, inferred as distributed RAM or registers.
- Latency: res_valid occurs 1 cycle after the final measurement strobe.

Optional Feature:
- Macro: SWEEP_RESPONSE_METER_DC_EN.
- Defined:
  - Add output res_dc [DW-1:0] = (sum of window samples) >> MEAS_LOG2.
  - The accumulator is DW+MEAS_LOG2 bits wide and clears on entry to MEASURE.
  - res_dc is valid alongside res_valid.
  - A second buffer is readable on rd_dc with the same 1-cycle latency.
- Undefined: no accumulator, no res_dc or rd_dc ports, and no change to any other behaviour.

Decomposition:
- Package sweep_pkg:
  - N_STEPS_DEF=50 and SAMPLE_RATE_HZ=163840.
  - Step index typedef step_idx_t (6-bit).
  - State enum meter_state_t.
  - The generator side should import the same N_STEPS and step_idx_t.
- Sub-module minmax_tracker: holds min/max registers with clear and update inputs, and outputs pp.

Test Plan (bench overrides SETTLE_SAMPLES=4, MEAS_LOG2=3):
- Amplitude: step_start with idx=5, then 12 strobes with samples 4 x 0xFFF (discarded) followed by 100,900,500,2000,1500,300,800,700.
  - Required: res_valid 1 cycle after the 12th strobe, res_idx=5, res_pp=1900.
  - Read rd_addr=5 and get rd_data=1900 one cycle later.
- Abort: step_start idx=7, 6 strobes, then step_start idx=8, then 12 strobes.
  - Required: err_abort=1, exactly one res_valid with res_idx=8, and buffer[7] unchanged.
- Sweep end: run idx=49 then idx=50.
  - Required: sweep_done pulses only in the idx=50 STORE cycle.
- Invalid index: step_start with idx=0, then with idx=51.
  - Required: err_idx=1, state stays IDLE, no res_valid.
- Collision and reset: assert sample_en with step_start in the same cycle and check that sample is not counted.
  - Assert rst=0 mid-MEASURE: outputs and flags clear, no write occurs.
- DC (with SWEEP_RESPONSE_METER_DC_EN defined): 8 measurement samples all equal to 0x800.
  - Required: res_dc=0x800, res_pp=0.
